sobel_tile_scheduler: RTL and testbench

- Sequences the sobel_edge_detector across a full frame.
- Walks the input frame buffer in 2x2 output tiles and fetches each tile's 4x4 pixel window over a single-port read interface.
- Presents the window to the detector through its bus_data_ready/need_data handshake.
- Writes the four returned output pixels to the output frame buffer at their image coordinates.

---
 rtl/sobel_tile_scheduler_if.sv | 43 ++++
 rtl/sobel_tile_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_sobel_tile_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_tile_scheduler_if.sv
// Signal bundle between the Sobel tile scheduler and its surroundings:
// control, input frame read port, detector handshake and output frame write port.
interface sobel_tile_scheduler_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_data;
    logic [63:0]       input_pixels;
    logic              bus_data_ready;
    logic              need_data;
    logic [3:0]        output_pixel;
    logic              output_enable;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;

    // Scheduler side
    modport master (
        input  start,
        output busy, done, err,
        output rd_en, rd_addr,
        input  rd_data,
        output input_pixels, bus_data_ready,
        input  need_data, output_pixel, output_enable,
        output wr_en, wr_addr, wr_data
    );

    // Environment side (frame buffers, detector, host)
    modport slave (
        output start,
        input  busy, done, err,
        input  rd_en, rd_addr,
        output rd_data,
        input  input_pixels, bus_data_ready,
        output need_data, output_pixel, output_enable,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sobel_tile_scheduler.sv
// Walks a frame in 2x2 output tiles: fetches each tile's 4x4 window from the
// input buffer, hands it to the Sobel detector and writes the four results
// back to the output buffer at their image coordinates.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_FETCH   | 16 reads of the 4x4 window plus the trailing capture cycle
// S_HANDOFF | window complete, waiting for need_data
// S_COLLECT | bus_data_ready pulse, then accepting four detector results
// S_ADVANCE | step to the next tile or finish the frame
// S_DONE    | one-cycle done pulse
module sobel_tile_scheduler #(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300,
    parameter int ADDR_W     = 17
) (
    input logic                      clk,
    input logic                      rst,
    sobel_tile_scheduler_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HANDOFF,
        S_COLLECT,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH - 3);
    localparam logic [ADDR_W-1:0] TILE_ROW = ADDR_W'(2 * IMG_WIDTH);
    localparam logic [ADDR_W-1:0] Q1_STEP  = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] WR_OFS   = ADDR_W'(IMG_WIDTH + 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A    = ADDR_W'(2);
    localparam logic [RW-1:0]     R_LAST   = RW'(IMG_HEIGHT - 4);
    localparam logic [CW-1:0]     C_LAST   = CW'(IMG_WIDTH - 4);

    state_t            r_state;
    logic [RW-1:0]     r_r;
    logic [CW-1:0]     r_c;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_tile_base;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic [3:0]        r_k;
    logic              r_cap_en;
    logic [3:0]        r_cap_k;
    logic [63:0]       r_shadow;
    logic [63:0]       r_pixels;
    logic              r_bdr;
    logic [1:0]        r_q;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [63:0]       w_win;
    logic              w_wr_valid;
    logic              w_proto_err;
    logic              w_c_wrap;
    logic              w_r_last;
    logic [ADDR_W-1:0] w_next_base;

    // Window being assembled, including the pixel arriving this cycle.
    // The visible window only changes once a fetch is complete, so the
    // detector never sees a half-built tile.
    always_comb begin
        w_win = r_shadow;
        w_win[{r_cap_k, 2'b00} +: 4] = bus.rd_data;
    end

    // A result is only accepted in COLLECT after the ready pulse; anything
    // else on output_enable is a protocol violation.
    assign w_wr_valid  = (r_state == S_COLLECT) && !r_bdr && bus.output_enable;
    assign w_proto_err = bus.output_enable && !w_wr_valid;

    assign w_c_wrap    = (r_c == C_LAST);
    assign w_r_last    = (r_r == R_LAST);
    assign w_next_base = w_c_wrap ? (r_row_base + TILE_ROW) : (r_tile_base + TWO_A);

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.err            = r_err;
    assign bus.rd_en          = r_rd_en;
    assign bus.rd_addr        = r_rd_addr;
    assign bus.input_pixels   = r_pixels;
    assign bus.bus_data_ready = r_bdr;
    assign bus.wr_en          = w_wr_valid;
    assign bus.wr_addr        = w_wr_valid ? r_wr_addr : '0;
    assign bus.wr_data        = w_wr_valid ? bus.output_pixel : 4'h0;

    // Tile sequencing FSM with registered outputs and incremental addressing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_r         <= '0;
            r_c         <= '0;
            r_row_base  <= '0;
            r_tile_base <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_k         <= '0;
            r_cap_en    <= 1'b0;
            r_cap_k     <= '0;
            r_shadow    <= '0;
            r_pixels    <= '0;
            r_bdr       <= 1'b0;
            r_q         <= '0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cap_en <= r_rd_en;
            r_cap_k  <= r_k;
            if (r_cap_en) begin
                r_shadow <= w_win;
            end
            if (w_proto_err) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err       <= w_proto_err;
                        r_r         <= '0;
                        r_c         <= '0;
                        r_row_base  <= '0;
                        r_tile_base <= '0;
                        r_rd_addr   <= '0;
                        r_rd_en     <= 1'b1;
                        r_k         <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (r_rd_en) begin
                        if (r_k == 4'd15) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            r_k       <= r_k + 4'd1;
                            r_rd_addr <= (r_k[1:0] == 2'd3) ? (r_rd_addr + ROW_STEP)
                                                            : (r_rd_addr + ONE_A);
                        end
                    end
                    if (r_cap_en && (r_cap_k == 4'd15)) begin
                        r_pixels <= w_win;
                        r_state  <= S_HANDOFF;
                    end
                end

                S_HANDOFF: begin
                    if (bus.need_data) begin
                        r_bdr     <= 1'b1;
                        r_q       <= '0;
                        r_wr_addr <= r_tile_base + WR_OFS;
                        r_state   <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    r_bdr <= 1'b0;
                    if (w_wr_valid) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0:    r_wr_addr <= r_wr_addr + ONE_A;
                            2'd1:    r_wr_addr <= r_wr_addr + Q1_STEP;
                            2'd2:    r_wr_addr <= r_wr_addr + ONE_A;
                            default: r_state   <= S_ADVANCE;
                        endcase
                    end
                end

                S_ADVANCE: begin
                    if (w_c_wrap) begin
                        r_c        <= '0;
                        r_r        <= r_r + RW'(2);
                        r_row_base <= r_row_base + TILE_ROW;
                    end else begin
                        r_c <= r_c + CW'(2);
                    end
                    if (w_c_wrap && w_r_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_tile_base <= w_next_base;
                        r_rd_addr   <= w_next_base;
                        r_rd_en     <= 1'b1;
                        r_k         <= '0;
                        r_state     <= S_FETCH;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_tile_scheduler.sv
// Directed bench for sobel_tile_scheduler on an 8x6 frame with
// pixel(row,col) = (row+col) & 0xF and a detector returning the window centre.
module tb_sobel_tile_scheduler;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sobel_tile_scheduler_if #(.ADDR_W(AW)) bus ();

    sobel_tile_scheduler #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_writes = 0;
    int n_done   = 0;
    int hits [W*H];
    int wr_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input frame buffer: one-cycle read latency.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? 4'((int'(bus.rd_addr) / W + int'(bus.rd_addr) % W) & 15) : 4'h0;
    end

    // Output frame buffer monitor: every write must carry (row+col)&0xF.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            check("wr_data", 64'(bus.wr_data),
                  64'((int'(bus.wr_addr) / W + int'(bus.wr_addr) % W) & 15));
            if (int'(bus.wr_addr) < W*H) hits[int'(bus.wr_addr)]++;
            wr_log.push_back(int'(bus.wr_addr));
            n_writes++;
        end
        if (bus.done === 1'b1) n_done++;
    end

    task automatic wait_bdr();
        int n = 0;
        while (bus.bus_data_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("bdr_seen", 64'(bus.bus_data_ready), 64'(1));
    endtask

    task automatic wait_rd_en();
        int n = 0;
        while (bus.rd_en !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("rd_en_seen", 64'(bus.rd_en), 64'(1));
    endtask

    // Detector: four results starting three cycles after bus_data_ready.
    task automatic run_detector(input bit extra);
        logic [63:0] win;
        wait_bdr();
        win = bus.input_pixels;
        tick();
        check("bdr_single", 64'(bus.bus_data_ready), 64'(0));
        tick();
        tick();
        for (int q = 0; q < 4; q++) begin
            bus.output_enable = 1'b1;
            case (q)
                0:       bus.output_pixel = win[23:20];
                1:       bus.output_pixel = win[27:24];
                2:       bus.output_pixel = win[39:36];
                default: bus.output_pixel = win[43:40];
            endcase
            tick();
        end
        if (extra) begin
            bus.output_pixel = 4'hF;
            #1;
            check("stray_no_write", 64'(bus.wr_en), 64'(0));
            tick();
            bus.output_enable = 1'b0;
            check("stray_err", 64'(bus.err), 64'(1));
        end else begin
            bus.output_enable = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] exp_win;
        int          bases [6];
        int          cover_ok;
        int          n;

        bases = '{0, 2, 4, 16, 18, 20};
        foreach (hits[a]) hits[a] = 0;

        bus.start         = 1'b0;
        bus.need_data     = 1'b0;
        bus.output_enable = 1'b0;
        bus.output_pixel  = 4'h0;

        // Reset state
        repeat (3) tick();
        check("rst_busy",   64'(bus.busy),           64'(0));
        check("rst_done",   64'(bus.done),           64'(0));
        check("rst_err",    64'(bus.err),            64'(0));
        check("rst_rd_en",  64'(bus.rd_en),          64'(0));
        check("rst_rdaddr", 64'(bus.rd_addr),        64'(0));
        check("rst_bdr",    64'(bus.bus_data_ready), 64'(0));
        check("rst_wr_en",  64'(bus.wr_en),          64'(0));
        check("rst_pixels", bus.input_pixels,        64'(0));
        rst = 1'b0;
        tick();

        // Stray output_enable while idle
        bus.output_enable = 1'b1;
        bus.output_pixel  = 4'h7;
        #1;
        check("idle_oe_no_write", 64'(bus.wr_en), 64'(0));
        tick();
        bus.output_enable = 1'b0;
        check("idle_oe_err", 64'(bus.err), 64'(1));

        // Frame 1
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", 64'(bus.busy), 64'(1));
        check("start_clears_err", 64'(bus.err), 64'(0));
        for (int k = 0; k < 16; k++) begin
            check("fetch_rd_en", 64'(bus.rd_en), 64'(1));
            check("fetch_rd_addr", 64'(bus.rd_addr), 64'((k >> 2) * W + (k & 3)));
            tick();
        end
        check("fetch_end_rd_en", 64'(bus.rd_en), 64'(0));
        tick();

        exp_win = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_win[16*i + 4*j +: 4] = 4'(i + j);
        check("win_first", bus.input_pixels, exp_win);
        check("win_const", bus.input_pixels, 64'h6543_5432_4321_3210);
        check("win_lsb", 64'(bus.input_pixels[3:0]), 64'(0));
        check("win_msb", 64'(bus.input_pixels[63:60]), 64'(6));

        // Detector not ready: no handoff, window stable
        for (int t = 0; t < 20; t++) begin
            check("hold_bdr", 64'(bus.bus_data_ready), 64'(0));
            check("hold_win", bus.input_pixels, exp_win);
            tick();
        end
        bus.need_data = 1'b1;
        run_detector(1'b1);

        for (int t = 1; t < 6; t++) begin
            wait_rd_en();
            check("tile_base", 64'(bus.rd_addr), 64'(bases[t]));
            run_detector(1'b0);
        end

        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", 64'(bus.done), 64'(1));
        check("done_busy_low", 64'(bus.busy), 64'(0));
        check("err_sticky", 64'(bus.err), 64'(1));
        tick();
        check("done_pulse_end", 64'(bus.done), 64'(0));
        check("done_count", 64'(n_done), 64'(1));
        check("write_count", 64'(n_writes), 64'(24));
        cover_ok = 0;
        for (int rr = 1; rr <= H - 2; rr++)
            for (int cc = 1; cc <= W - 2; cc++)
                if (hits[rr*W + cc] == 1) cover_ok++;
        check("interior_once", 64'(cover_ok), 64'(24));
        check("wr0", 64'(wr_log[0]), 64'(9));
        check("wr1", 64'(wr_log[1]), 64'(10));
        check("wr2", 64'(wr_log[2]), 64'(17));
        check("wr3", 64'(wr_log[3]), 64'(18));

        // Frame 2: abandoned by reset during COLLECT of tile 3
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_clears_err", 64'(bus.err), 64'(0));
        check("restart_busy", 64'(bus.busy), 64'(1));
        for (int t = 0; t < 2; t++) begin
            wait_rd_en();
            check("f2_tile_base", 64'(bus.rd_addr), 64'(bases[t]));
            run_detector(1'b0);
        end
        wait_rd_en();
        check("f2_tile3_base", 64'(bus.rd_addr), 64'(bases[2]));
        wait_bdr();
        tick();
        tick();
        tick();
        bus.output_enable = 1'b1;
        bus.output_pixel  = bus.input_pixels[23:20];
        tick();
        bus.output_pixel  = bus.input_pixels[27:24];
        tick();
        rst = 1'b1;
        #1;
        check("abort_wr_en",  64'(bus.wr_en),          64'(0));
        check("abort_wrdata", 64'(bus.wr_data),        64'(0));
        check("abort_busy",   64'(bus.busy),           64'(0));
        check("abort_rd_en",  64'(bus.rd_en),          64'(0));
        check("abort_bdr",    64'(bus.bus_data_ready), 64'(0));
        check("abort_done",   64'(bus.done),           64'(0));
        check("abort_pixels", bus.input_pixels,        64'(0));
        tick();
        rst = 1'b0;
        bus.output_enable = 1'b0;
        tick();
        check("abort_no_done", 64'(n_done), 64'(1));

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart2_rd_en", 64'(bus.rd_en), 64'(1));
        check("restart2_rd_addr", 64'(bus.rd_addr), 64'(0));
        check("restart2_busy", 64'(bus.busy), 64'(1));
        repeat (30) tick();
        check("still_one_done", 64'(n_done), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
